// File: rtl/mem_arbiter.sv
// Byte-serial external memory arbiter between the instruction-fetch (IF) and load/store (LS) ports.
// Optional IF anti-starvation arbitration is compiled in with `define MEM_ARB_FAIR_EN.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_abort,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  ls_req,
  input  logic                  ls_wr,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [2:0]            ls_size,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_done,
  output logic [31:0]           ls_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_a
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, TAIL = 2'd2} state_t;

  typedef struct packed {
    state_t                state;
    logic                  owner_ls;
    logic                  op_wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            last;
    logic [31:0]           wdata;
    logic [1:0]            beat;
    logic [31:0]           rbuf;
    logic                  rd_pend;
    logic [1:0]            rd_idx;
    logic                  abort;
    logic                  if_done;
    logic [31:0]           if_data;
    logic                  ls_done;
    logic [31:0]           ls_rdata;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic                  mem_wr;
    logic [7:0]            mem_dout;
  } regs_t;

  regs_t r, n;
  logic  if_pend, if_first, idle_go, grant_ls, grant_if;
  logic [31:0] cap;

  function automatic logic [1:0] size_last(input logic [2:0] size);
    case (size)
      3'd1:    return 2'd0;
      3'd2:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  assign if_pend  = if_req && !if_abort;
  assign idle_go  = (r.state == IDLE) && rdy;
  assign grant_ls = idle_go && ls_req && !if_first;
  assign grant_if = idle_go && if_pend && !grant_ls;

`ifdef MEM_ARB_FAIR_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q, starve_n;

  assign if_first = if_pend && (starve_q >= SW'(STARVE_MAX));

  always_comb begin
    starve_n = starve_q;
    if (!if_req || grant_if)    starve_n = '0;
    else if (grant_ls && if_pend) starve_n = starve_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_n;
  end
`else
  // Strict LS priority; STARVE_MAX only has meaning with fairness enabled.
  assign if_first = (STARVE_MAX < 0);
`endif

  always_comb begin
    // NOTE: take a full copy of the registers first so every field has a value on every path (no latches).
    n         = r;
    n.if_done = 1'b0;
    n.ls_done = 1'b0;
    // A read byte arrives the cycle after a beat that was actually issued, even if that cycle stalls.
    n.rd_pend = (r.state == ISSUE) && !r.op_wr && rdy;
    n.rd_idx  = r.beat;
    cap       = r.rbuf;
    if (r.rd_pend) cap[{r.rd_idx, 3'b000} +: 8] = mem_din;
    n.rbuf    = cap;
    if (r.state != IDLE && !r.owner_ls && if_abort) n.abort = 1'b1;

    case (r.state)
      IDLE: begin
        if (grant_ls || grant_if) begin
          n.state    = ISSUE;
          n.owner_ls = grant_ls;
          n.op_wr    = grant_ls && ls_wr;
          n.addr     = grant_ls ? ls_addr : if_addr;
          n.last     = grant_ls ? size_last(ls_size) : 2'd3;
          n.wdata    = grant_ls ? ls_wdata : 32'h0;
          n.beat     = 2'd0;
          n.rbuf     = 32'h0;
          n.abort    = 1'b0;
          n.mem_a    = n.addr;
          n.mem_wr   = n.op_wr;
          n.mem_dout = n.wdata[7:0];
        end
      end
      ISSUE: begin
        if (rdy) begin
          if (r.beat == r.last) begin
            n.mem_a    = '0;
            n.mem_wr   = 1'b0;
            n.mem_dout = 8'h0;
            if (r.op_wr) begin
              n.state   = IDLE;
              n.ls_done = 1'b1;
            end else begin
              n.state = TAIL;
            end
          end else begin
            n.beat     = r.beat + 2'd1;
            n.mem_a    = r.addr + ADDR_WIDTH'(n.beat);
            n.mem_dout = r.wdata[{n.beat, 3'b000} +: 8];
          end
        end
      end
      TAIL: begin
        if (rdy) begin
          n.state = IDLE;
          if (r.owner_ls) begin
            n.ls_done  = 1'b1;
            n.ls_rdata = cap;
          end else if (!n.abort) begin
            n.if_done = 1'b1;
            n.if_data = cap;
          end
        end
      end
      default: n.state = IDLE;
    endcase
  end

  // NOTE: the whole register set, including the read assembly buffer, is reset so a reset mid-transfer leaves nothing half-done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r <= '0;
    else     r <= n;
  end

  assign if_done  = r.if_done;
  assign if_data  = r.if_data;
  assign ls_done  = r.ls_done;
  assign ls_rdata = r.ls_rdata;
  assign mem_a    = r.mem_a;
  assign mem_dout = r.mem_dout;
  // Write strobe is masked while frozen so a held beat is never written twice.
  assign mem_wr   = r.mem_wr && rdy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: byte-wide memory model, expected reads/writes queued at issue.
// Define MEM_ARB_FAIR_EN to also exercise the starvation-limit grant order.
module tb_mem_arbiter;
  localparam int AW = 32;
`ifdef MEM_ARB_FAIR_EN
  localparam int SMAX = 2;
`else
  localparam int SMAX = 8;
`endif

  logic          clk, rst, rdy;
  logic          if_req, if_abort, if_done;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_data;
  logic          ls_req, ls_wr, ls_done;
  logic [AW-1:0] ls_addr;
  logic [2:0]    ls_size;
  logic [31:0]   ls_wdata, ls_rdata;
  logic [7:0]    mem_din, mem_dout;
  logic          mem_wr;
  logic [AW-1:0] mem_a;

  mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
    .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_a(mem_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory: writes commit at the edge, read data appears the cycle after its address.
  logic [7:0] mem_model [0:65535];
  always @(posedge clk) begin
    if (mem_wr) mem_model[mem_a[15:0]] <= mem_dout;
    mem_din <= mem_model[mem_a[15:0]];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] data;
  } ls_exp_t;

  logic [31:0] if_q [$];
  ls_exp_t     ls_q [$];
  logic [39:0] wr_q [$];
  int          done_log [$];
  int          wr_cnt = 0, rd_beats = 0, if_done_cnt = 0;
  logic        watch_en = 1'b0;
  logic [31:0] watch_lo = 32'h0;
  ls_exp_t     mon_e;
  logic [39:0] mon_w;

  // Output monitor, sampled 1 ns after the falling edge (after any stimulus change).
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (if_done) begin
        if_done_cnt++;
        done_log.push_back(1);
        if (if_q.size() == 0) check("if_extra", 32'(if_done), 32'd0);
        else                  check("if_data", if_data, if_q.pop_front());
      end
      if (ls_done) begin
        done_log.push_back(0);
        if (ls_q.size() == 0) check("ls_extra", 32'(ls_done), 32'd0);
        else begin
          mon_e = ls_q.pop_front();
          if (mon_e.wr) check("st_beats_left", 32'(wr_q.size()), 32'd0);
          else          check("ls_rdata", ls_rdata, mon_e.data);
        end
      end
      if (mem_wr) begin
        wr_cnt++;
        if (wr_q.size() == 0) check("wr_extra", 32'(mem_wr), 32'd0);
        else begin
          mon_w = wr_q.pop_front();
          check("wr_addr", mem_a, mon_w[39:8]);
          check("wr_data", 32'(mem_dout), 32'(mon_w[7:0]));
        end
      end
      if (watch_en && !mem_wr && (mem_a - watch_lo) < 32'd4) rd_beats++;
    end
  end

  function automatic logic [31:0] model_read(input logic [31:0] a, input int nb);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_model[16'(a + 32'(i))];
    return v;
  endfunction

  function automatic int size_bytes(input logic [2:0] sz);
    return (sz == 3'd1) ? 1 : (sz == 3'd2) ? 2 : 4;
  endfunction

  // Queue the expected effects of an LS request and raise it (caller is at a falling edge).
  task automatic ls_start(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] wd);
    ls_exp_t e;
    int nb;
    nb     = size_bytes(sz);
    e.wr   = wr;
    e.data = wr ? 32'h0 : model_read(a, nb);
    if (wr) for (int i = 0; i < nb; i++) wr_q.push_back({a + 32'(i), wd[8*i +: 8]});
    ls_q.push_back(e);
    ls_wr = wr; ls_addr = a; ls_size = sz; ls_wdata = wd; ls_req = 1'b1;
  endtask

  task automatic wait_ls(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ls_done && lat < 100);
    if (!ls_done) check("ls_timeout", 32'(ls_done), 32'd1);
  endtask

  task automatic wait_if(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!if_done && lat < 100);
    if (!if_done) check("if_timeout", 32'(if_done), 32'd1);
  endtask

  task automatic do_ls(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, output int lat);
    ls_start(wr, a, sz, wd);
    wait_ls(lat);
    ls_req = 1'b0;
  endtask

  task automatic do_if(input logic [31:0] a, output int lat);
    if_q.push_back(model_read(a, 4));
    if_addr = a; if_req = 1'b1;
    wait_if(lat);
    if_req = 1'b0;
  endtask

  int lat, n0, w0;

  initial begin
    for (int i = 0; i < 65536; i++) mem_model[i] = 8'(i * 7 + 3);
    mem_model[16'h0100] = 8'h13; mem_model[16'h0101] = 8'h00;
    mem_model[16'h0102] = 8'h00; mem_model[16'h0103] = 8'h00;
    rst = 1'b1; rdy = 1'b1;
    if_req = 1'b0; if_abort = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_addr = '0; ls_size = 3'd4; ls_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_if_done", 32'(if_done), 32'd0);
    check("rst_ls_done", 32'(ls_done), 32'd0);
    check("rst_if_data", if_data, 32'h0);
    check("rst_ls_rdata", ls_rdata, 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_dout", 32'(mem_dout), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Word fetch: done six cycles after the grant.
    do_if(32'h0000_0100, lat);
    check("if_lat", 32'(lat), 32'd6);
    check("if_word", if_data, 32'h0000_0013);

    // Halfword store, then read it back with several sizes.
    do_ls(1'b1, 32'h0000_1004, 3'd2, 32'h0000_BEEF, lat);
    check("st2_lat", 32'(lat), 32'd3);
    @(negedge clk);
    check("st2_byte0", 32'(mem_model[16'h1004]), 32'h0000_00EF);
    check("st2_byte1", 32'(mem_model[16'h1005]), 32'h0000_00BE);
    do_ls(1'b0, 32'h0000_1004, 3'd2, 32'h0, lat);
    check("ld2_lat", 32'(lat), 32'd4);
    check("ld2_data", ls_rdata, 32'h0000_BEEF);
    do_ls(1'b0, 32'h0000_1005, 3'd1, 32'h0, lat);
    check("ld1_lat", 32'(lat), 32'd3);
    do_ls(1'b0, 32'h0000_1004, 3'd7, 32'h0, lat);
    check("ld7_lat", 32'(lat), 32'd6);

    // Simultaneous requests: LS wins, IF follows.
    @(negedge clk);
    done_log.delete();
    if_q.push_back(model_read(32'h0000_0200, 4));
    if_addr = 32'h0000_0200; if_req = 1'b1;
    ls_start(1'b0, 32'h0000_0020, 3'd1, 32'h0);
    lat = 0;
    while (lat < 100) begin
      @(negedge clk); lat++;
      if (ls_done) ls_req = 1'b0;
      if (if_done) break;
    end
    if (!if_done) check("both_timeout", 32'(if_done), 32'd1);
    if_req = 1'b0; ls_req = 1'b0;
    #2;
    check("prio_count", 32'(done_log.size()), 32'd2);
    check("prio_first_ls", 32'(done_log[0]), 32'd0);
    check("prio_then_if", 32'(done_log[1]), 32'd1);

    // Fetch aborted one cycle after its grant: all beats run, no done pulse.
    @(negedge clk);
    watch_lo = 32'h0000_0300; watch_en = 1'b1; rd_beats = 0; n0 = if_done_cnt;
    if_addr = 32'h0000_0300; if_req = 1'b1;
    @(negedge clk);
    if_req = 1'b0; if_abort = 1'b1;
    @(negedge clk);
    if_abort = 1'b0;
    repeat (10) @(negedge clk);
    watch_en = 1'b0;
    check("abort_beats", 32'(rd_beats), 32'd4);
    check("abort_no_done", 32'(if_done_cnt - n0), 32'd0);

    // Word store with a three-cycle freeze after the first beat.
    w0 = wr_cnt;
    ls_start(1'b1, 32'h0000_2000, 3'd4, 32'hDDCC_BBAA);
    repeat (2) @(negedge clk);
    rdy = 1'b0;
    repeat (3) begin
      #1 check("stall_wr_low", 32'(mem_wr), 32'd0);
      @(negedge clk);
    end
    rdy = 1'b1;
    wait_ls(lat);
    ls_req = 1'b0;
    @(negedge clk);
    check("stall_wr_count", 32'(wr_cnt - w0), 32'd4);
    check("stall_mem_word", {mem_model[16'h2003], mem_model[16'h2002],
                             mem_model[16'h2001], mem_model[16'h2000]}, 32'hDDCC_BBAA);

    // Fetch frozen mid-read; the byte returning in the first frozen cycle must be kept.
    if_q.push_back(model_read(32'h0000_0700, 4));
    if_addr = 32'h0000_0700; if_req = 1'b1;
    repeat (3) @(negedge clk);
    rdy = 1'b0;
    repeat (2) @(negedge clk);
    rdy = 1'b1;
    wait_if(lat);
    if_req = 1'b0;

    // Address wrap at the top of the space, then a back-to-back load.
    do_ls(1'b0, 32'hFFFF_FFFE, 3'd4, 32'h0, lat);
    check("wrap_data", ls_rdata, model_read(32'hFFFF_FFFE, 4));
    do_ls(1'b0, 32'h0000_0044, 3'd4, 32'h0, lat);
    check("b2b_lat", 32'(lat), 32'd6);

    // Reset in the middle of a fetch: bus idles, no done pulse.
    @(negedge clk);
    n0 = if_done_cnt;
    if_addr = 32'h0000_0500; if_req = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1; if_req = 1'b0;
    #1;
    check("rst_mid_mem_a", mem_a, 32'h0);
    check("rst_mid_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mid_if_data", if_data, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_mid_no_done", 32'(if_done_cnt - n0), 32'd0);

`ifdef MEM_ARB_FAIR_EN
    // Both ports requesting continuously: two LS grants, then IF.
    done_log.delete();
    for (int i = 0; i < 3; i++) ls_q.push_back('{1'b0, model_read(32'h0000_0040, 1)});
    for (int i = 0; i < 2; i++) if_q.push_back(model_read(32'h0000_0600, 4));
    ls_q.push_back('{1'b0, model_read(32'h0000_0040, 1)});
    ls_wr = 1'b0; ls_addr = 32'h0000_0040; ls_size = 3'd1; ls_req = 1'b1;
    if_addr = 32'h0000_0600; if_req = 1'b1;
    lat = 0;
    while (done_log.size() < 6 && lat < 300) begin
      @(negedge clk); #2; lat++;
    end
    ls_req = 1'b0; if_req = 1'b0;
    check("fair_count", 32'(done_log.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("fair_order%0d", i), 32'(done_log[i]), (i % 3 == 2) ? 32'd1 : 32'd0);
    repeat (10) @(negedge clk);
`endif

    check("if_q_drained", 32'(if_q.size()), 32'd0);
    check("ls_q_drained", 32'(ls_q.size()), 32'd0);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
